data_bus_ctrl: RTL and testbench

DATA_BUS_CTRL -- requirements
Module: data_bus_ctrl

---
 rtl/data_bus_ctrl_pkg.sv | 44 ++++
 rtl/data_bus_ctrl_if.sv | 26 ++
 rtl/data_bus_ctrl_load_extend.sv | 36 +++
 rtl/data_bus_ctrl.sv | 118 +++++++++++
 tb/tb_data_bus_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_ctrl_pkg.sv
// Shared constants for the data bus controller: transfer size codes, FSM
// state codes, default ACKD_n timeout and request/lane helper functions.
package data_bus_ctrl_pkg;

   localparam int unsigned TIMEOUT_DEFAULT = 16;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ACCESS   = 2'b01,
      ST_COMPLETE = 2'b10
   } state_e;

   // True when the size code is legal and the address is naturally aligned.
   function automatic logic size_aligned(input size_e size, input logic [1:0] addr_lo);
      logic ok;
      ok = 1'b0;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~addr_lo[0];
         SZ_WORD: ok = (addr_lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Replicate right-aligned store data across all byte lanes.
   function automatic logic [31:0] store_lanes(input size_e size, input logic [31:0] wdata);
      logic [31:0] lanes;
      case (size)
         SZ_BYTE: lanes = {4{wdata[7:0]}};
         SZ_HALF: lanes = {2{wdata[15:0]}};
         default: lanes = wdata;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/data_bus_ctrl_if.sv
// MEM-stage request/response handshake between the pipeline (master) and
// the data bus controller (slave).
//   req_read/req_write/req_addr/req_wdata/req_size/req_signed : request
//   rdata : extended load result, busy : stall, done/err : one-cycle pulses
interface data_bus_ctrl_if;
   logic        req_read;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output req_read, req_write, req_addr, req_wdata, req_size, req_signed,
      input  rdata, busy, done, err
   );

   modport slave (
      input  req_read, req_write, req_addr, req_wdata, req_size, req_signed,
      output rdata, busy, done, err
   );
endinterface

// File: rtl/data_bus_ctrl_load_extend.sv
// Load lane extraction: selects the byte (addr[1:0]) or halfword (addr[1])
// lane from the bus word and sign- or zero-extends it; words pass through.
//   data      : raw 32-bit bus word
//   addr_lo   : low address bits of the access
//   size      : transfer size code
//   is_signed : sign-extend when set
//   result    : extended 32-bit load value
module load_extend
   import data_bus_ctrl_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  addr_lo,
   input  size_e       size,
   input  logic        is_signed,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_v = data[7:0];
         2'd1:    byte_v = data[15:8];
         2'd2:    byte_v = data[23:16];
         default: byte_v = data[31:24];
      endcase
      half_v = addr_lo[1] ? data[31:16] : data[15:0];
      case (size)
         SZ_BYTE: result = {{24{is_signed & byte_v[7]}}, byte_v};
         SZ_HALF: result = {{16{is_signed & half_v[15]}}, half_v};
         default: result = data;
      endcase
   end

endmodule

// File: rtl/data_bus_ctrl.sv
// Data bus controller: turns single MEM-stage load/store requests into
// external bus cycles (MREQ/DAD/SIZE/WRITE/DDT, acknowledged by ACKD_n),
// with alignment checking, lane steering and an ACKD_n timeout.
//   clk, rst : clock, synchronous active-high reset
//   mem      : request/response handshake (slave side)
//   DAD      : bus address       MREQ  : bus cycle active
//   WRITE    : store cycle       SIZE  : transfer size
//   DDT      : bidirectional data, driven only during a store ACCESS
//   ACKD_n   : active-low acknowledge, only looked at in ACCESS
module data_bus_ctrl
   import data_bus_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   data_bus_ctrl_if.slave     mem,
   output logic [31:0]        DAD,
   output logic               MREQ,
   output logic               WRITE,
   output logic [1:0]         SIZE,
   inout  logic [31:0]        DDT,
   input  logic               ACKD_n
);

   localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_CYCLES - 1);

   state_e      state;
   logic [3:0]  cnt;
   logic [31:0] rdata_q;
   logic        done_q;
   logic        err_q;
   logic        sgn_q;
   logic        ddt_oe;
   logic [31:0] ddt_out;
   logic [31:0] ext_data;
   logic        req_any;
   logic        req_valid;

   always_comb begin
      req_any   = mem.req_read | mem.req_write;
      req_valid = (mem.req_read ^ mem.req_write) &&
                  size_aligned(size_e'(mem.req_size), mem.req_addr[1:0]);
   end

   load_extend u_load_extend (
      .data      (DDT),
      .addr_lo   (DAD[1:0]),
      .size      (size_e'(SIZE)),
      .is_signed (sgn_q),
      .result    (ext_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         sgn_q   <= 1'b0;
         MREQ    <= 1'b0;
         WRITE   <= 1'b0;
         SIZE    <= '0;
         DAD     <= '0;
         ddt_oe  <= 1'b0;
         ddt_out <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  state   <= ST_ACCESS;
                  cnt     <= '0;
                  sgn_q   <= mem.req_signed;
                  MREQ    <= 1'b1;
                  WRITE   <= mem.req_write;
                  SIZE    <= mem.req_size;
                  DAD     <= mem.req_addr;
                  ddt_oe  <= mem.req_write;
                  ddt_out <= store_lanes(size_e'(mem.req_size), mem.req_wdata);
               end else if (req_any) begin
                  err_q <= 1'b1;
               end
            end
            ST_ACCESS: begin
               // WRITE still holds the latched direction while in ACCESS.
               if (!ACKD_n) begin
                  if (!WRITE) rdata_q <= ext_data;
                  state  <= ST_COMPLETE;
                  done_q <= 1'b1;
                  MREQ   <= 1'b0;
                  WRITE  <= 1'b0;
                  ddt_oe <= 1'b0;
               end else if (cnt == TMO_LAST) begin
                  state  <= ST_IDLE;
                  err_q  <= 1'b1;
                  MREQ   <= 1'b0;
                  WRITE  <= 1'b0;
                  ddt_oe <= 1'b0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_COMPLETE: state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

   assign DDT       = ddt_oe ? ddt_out : 'z;
   assign mem.rdata = rdata_q;
   assign mem.done  = done_q;
   assign mem.err   = err_q;
   assign mem.busy  = ((state == ST_IDLE) && req_valid) || (state == ST_ACCESS);

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed self-checking bench for data_bus_ctrl. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_data_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dad;
   logic        mreq;
   logic        write;
   logic [1:0]  size;
   logic        ackd_n;
   logic        ddt_en;
   logic [31:0] ddt_val;
   wire  [31:0] ddt;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] data;
      logic [31:0] exp;
   } ld_vec_t;

   always #5 clk = ~clk;

   assign ddt = ddt_en ? ddt_val : 'z;

   data_bus_ctrl_if mem_if ();

   data_bus_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .mem    (mem_if.slave),
      .DAD    (dad),
      .MREQ   (mreq),
      .WRITE  (write),
      .SIZE   (size),
      .DDT    (ddt),
      .ACKD_n (ackd_n)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_req();
      mem_if.req_read   = 1'b0;
      mem_if.req_write  = 1'b0;
      mem_if.req_addr   = '0;
      mem_if.req_wdata  = '0;
      mem_if.req_size   = 2'b00;
      mem_if.req_signed = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({mreq, write, size, dad} !== 36'h0)
         $display("FAIL reset_bus: MREQ/WRITE/SIZE/DAD=%h expected 0", {mreq, write, size, dad});
      else passed++;
      checks++;
      if ({mem_if.rdata, mem_if.done, mem_if.err, mem_if.busy} !== 35'h0)
         $display("FAIL reset_resp: rdata=%h done=%b err=%b busy=%b expected all 0",
                  mem_if.rdata, mem_if.done, mem_if.err, mem_if.busy);
      else passed++;
      ddt_en = 1'b1; ddt_val = 32'hA5A5_A5A5;
      #1;
      checks++;
      if (ddt !== 32'hA5A5_A5A5) $display("FAIL reset_ddt_hiz: DDT=%h expected %h", ddt, 32'hA5A5_A5A5);
      else passed++;
      ddt_en = 1'b0;
      rst = 1'b0;
      // Acknowledge outside ACCESS must be ignored.
      ackd_n = 1'b0;
      step();
      step();
      checks++;
      if ({mem_if.done, mem_if.err, mreq} !== 3'b000)
         $display("FAIL idle_ack_ignored: done/err/MREQ=%b expected 000", {mem_if.done, mem_if.err, mreq});
      else passed++;
      ackd_n = 1'b1;
   endtask

   task automatic test_word_load();
      int mreq_n;
      int done_n;
      mem_if.req_read = 1'b1;
      mem_if.req_addr = 32'h100;
      mem_if.req_size = 2'b10;
      #1;
      checks++;
      if (mem_if.busy !== 1'b1) $display("FAIL wload_busy_idle: busy=%b expected 1", mem_if.busy);
      else passed++;
      step();
      mreq_n = 0;
      for (int i = 0; i < 3; i++) begin
         if (mreq === 1'b1) mreq_n++;
         checks++;
         if ({dad, size, write, mem_if.busy} !== {32'h100, 2'b10, 1'b0, 1'b1})
            $display("FAIL wload_access_%0d: DAD=%h SIZE=%b WRITE=%b busy=%b expected 100 10 0 1",
                     i, dad, size, write, mem_if.busy);
         else passed++;
         if (i == 2) begin
            ackd_n = 1'b0; ddt_en = 1'b1; ddt_val = 32'hDEAD_BEEF;
         end
         step();
      end
      checks++;
      if (mreq_n !== 3) $display("FAIL wload_mreq_cycles: got %0d expected 3", mreq_n);
      else passed++;
      checks++;
      if ({mreq, mem_if.busy, mem_if.rdata} !== {1'b0, 1'b0, 32'hDEAD_BEEF})
         $display("FAIL wload_complete: MREQ=%b busy=%b rdata=%h expected 0 0 deadbeef",
                  mreq, mem_if.busy, mem_if.rdata);
      else passed++;
      done_n = (mem_if.done === 1'b1) ? 1 : 0;
      clear_req();
      ackd_n = 1'b1; ddt_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (mem_if.done === 1'b1) done_n++;
      end
      checks++;
      if (done_n !== 1) $display("FAIL wload_done_pulses: got %0d expected 1", done_n);
      else passed++;
      checks++;
      if (mem_if.rdata !== 32'hDEAD_BEEF) $display("FAIL wload_rdata_hold: rdata=%h expected deadbeef", mem_if.rdata);
      else passed++;
   endtask

   task automatic test_timeout();
      int mreq_n;
      mem_if.req_read = 1'b1;
      mem_if.req_addr = 32'h300;
      mem_if.req_size = 2'b10;
      ackd_n = 1'b1;
      ddt_en = 1'b1; ddt_val = 32'h1111_1111;
      step();
      mreq_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (mreq !== 1'b1) break;
         if (mem_if.err === 1'b1) begin
            checks++;
            $display("FAIL tmo_early_err: err=1 after %0d ACCESS cycles", mreq_n);
         end
         mreq_n++;
         step();
      end
      checks++;
      if (mreq_n !== 16) $display("FAIL tmo_access_cycles: got %0d expected 16", mreq_n);
      else passed++;
      checks++;
      if ({mem_if.err, mem_if.done, mem_if.rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF})
         $display("FAIL tmo_err: err=%b done=%b rdata=%h expected 1 0 deadbeef",
                  mem_if.err, mem_if.done, mem_if.rdata);
      else passed++;
      clear_req();
      ddt_en = 1'b0;
      step();
      checks++;
      if ({mem_if.err, mreq} !== 2'b00) $display("FAIL tmo_err_pulse: err/MREQ=%b expected 00", {mem_if.err, mreq});
      else passed++;
   endtask

   task automatic test_load_extend();
      ld_vec_t lv[5];
      lv[0] = '{32'h103, 2'b00, 1'b1, 32'h8000_0000, 32'hFFFF_FF80};
      lv[1] = '{32'h103, 2'b00, 1'b0, 32'h8000_0000, 32'h0000_0080};
      lv[2] = '{32'h102, 2'b01, 1'b1, 32'h9ABC_1234, 32'hFFFF_9ABC};
      lv[3] = '{32'h100, 2'b01, 1'b0, 32'h9ABC_8234, 32'h0000_8234};
      lv[4] = '{32'h101, 2'b00, 1'b1, 32'h1122_7F44, 32'h0000_007F};
      for (int i = 0; i < 5; i++) begin
         mem_if.req_read   = 1'b1;
         mem_if.req_addr   = lv[i].addr;
         mem_if.req_size   = lv[i].size;
         mem_if.req_signed = lv[i].sgn;
         step();
         ackd_n = 1'b0; ddt_en = 1'b1; ddt_val = lv[i].data;
         step();
         checks++;
         if ({mem_if.done, mem_if.rdata} !== {1'b1, lv[i].exp})
            $display("FAIL ld_ext_%0d: done=%b rdata=%h expected 1 %h", i, mem_if.done, mem_if.rdata, lv[i].exp);
         else passed++;
         clear_req();
         ackd_n = 1'b1; ddt_en = 1'b0;
         step();
      end
   endtask

   task automatic test_half_store();
      mem_if.req_write = 1'b1;
      mem_if.req_addr  = 32'h202;
      mem_if.req_wdata = 32'h1234_ABCD;
      mem_if.req_size  = 2'b01;
      step();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({mreq, write, size, dad, ddt} !== {1'b1, 1'b1, 2'b01, 32'h202, 32'hABCD_ABCD})
            $display("FAIL st_access_%0d: MREQ=%b WRITE=%b SIZE=%b DAD=%h DDT=%h expected 1 1 01 202 abcdabcd",
                     i, mreq, write, size, dad, ddt);
         else passed++;
         if (i == 1) ackd_n = 1'b0;
         step();
      end
      checks++;
      if ({mem_if.done, mreq, write, mem_if.rdata} !== {1'b1, 1'b0, 1'b0, 32'h0000_007F})
         $display("FAIL st_complete: done=%b MREQ=%b WRITE=%b rdata=%h expected 1 0 0 0000007f",
                  mem_if.done, mreq, write, mem_if.rdata);
      else passed++;
      clear_req();
      ackd_n = 1'b1;
      ddt_en = 1'b1; ddt_val = 32'h5A5A_A5A5;
      #1;
      checks++;
      if (ddt !== 32'h5A5A_A5A5) $display("FAIL st_ddt_hiz: DDT=%h expected 5a5aa5a5", ddt);
      else passed++;
      ddt_en = 1'b0;
      step();
   endtask

   task automatic test_invalid();
      logic [37:0] iv[3];
      // {read, write, size, addr}
      iv[0] = {1'b1, 1'b0, 2'b10, 32'h101};
      iv[1] = {1'b1, 1'b1, 2'b10, 32'h100};
      iv[2] = {1'b1, 1'b0, 2'b11, 32'h100};
      for (int i = 0; i < 3; i++) begin
         {mem_if.req_read, mem_if.req_write, mem_if.req_size, mem_if.req_addr} = iv[i];
         #1;
         checks++;
         if (mem_if.busy !== 1'b0) $display("FAIL inv_busy_%0d: busy=%b expected 0", i, mem_if.busy);
         else passed++;
         step();
         checks++;
         if ({mem_if.err, mreq, mem_if.busy} !== 3'b100)
            $display("FAIL inv_err_%0d: err/MREQ/busy=%b expected 100", i, {mem_if.err, mreq, mem_if.busy});
         else passed++;
         clear_req();
         step();
         checks++;
         if ({mem_if.err, mreq} !== 2'b00) $display("FAIL inv_after_%0d: err/MREQ=%b expected 00", i, {mem_if.err, mreq});
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      mem_if.req_read = 1'b1;
      mem_if.req_addr = 32'h200;
      mem_if.req_size = 2'b10;
      step();
      ackd_n = 1'b0; ddt_en = 1'b1; ddt_val = 32'hCAFE_F00D;
      step();
      ackd_n = 1'b1; ddt_en = 1'b0;
      mem_if.req_addr = 32'h204;
      #1;
      checks++;
      if ({mem_if.done, mem_if.busy, mem_if.rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D})
         $display("FAIL b2b_complete: done=%b busy=%b rdata=%h expected 1 0 cafef00d",
                  mem_if.done, mem_if.busy, mem_if.rdata);
      else passed++;
      step();
      checks++;
      if ({mreq, mem_if.done, mem_if.busy} !== 3'b001)
         $display("FAIL b2b_reeval: MREQ/done/busy=%b expected 001", {mreq, mem_if.done, mem_if.busy});
      else passed++;
      step();
      checks++;
      if ({mreq, dad} !== {1'b1, 32'h204}) $display("FAIL b2b_second: MREQ=%b DAD=%h expected 1 204", mreq, dad);
      else passed++;
      ackd_n = 1'b0; ddt_en = 1'b1; ddt_val = 32'h0BAD_C0DE;
      step();
      checks++;
      if ({mem_if.done, mem_if.rdata} !== {1'b1, 32'h0BAD_C0DE})
         $display("FAIL b2b_second_done: done=%b rdata=%h expected 1 0badc0de", mem_if.done, mem_if.rdata);
      else passed++;
      clear_req();
      ackd_n = 1'b1; ddt_en = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_access();
      mem_if.req_read = 1'b1;
      mem_if.req_addr = 32'h400;
      mem_if.req_size = 2'b10;
      step();
      step();
      step();
      checks++;
      if (mreq !== 1'b1) $display("FAIL rst_mid_pre: MREQ=%b expected 1", mreq);
      else passed++;
      rst = 1'b1;
      clear_req();
      step();
      checks++;
      if ({mreq, mem_if.done, mem_if.err, mem_if.busy, mem_if.rdata} !== 36'h0)
         $display("FAIL rst_mid_abort: MREQ=%b done=%b err=%b busy=%b rdata=%h expected all 0",
                  mreq, mem_if.done, mem_if.err, mem_if.busy, mem_if.rdata);
      else passed++;
      rst = 1'b0;
      step();
      checks++;
      if ({mreq, mem_if.done, mem_if.err} !== 3'b000)
         $display("FAIL rst_mid_after: MREQ/done/err=%b expected 000", {mreq, mem_if.done, mem_if.err});
      else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      ackd_n = 1'b1;
      ddt_en = 1'b0;
      ddt_val = '0;
      clear_req();
      test_reset();
      test_word_load();
      test_timeout();
      test_load_extend();
      test_half_store();
      test_invalid();
      test_back_to_back();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
